parity_frame_ctrl: RTL and testbench

//  Sequencer for the serial parity path. Accepts a parallel word plus its

---
 rtl/parity_frame_ctrl.sv | 136 +++++++++++++
 tb/tb_parity_frame_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for the serial parity path: accepts a word plus its received
// parity, shifts it out LSB-first and reports the computed parity and error count.
module parity_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    output logic              ser_x,
    output logic              ser_en,
    output logic              par_run,
    output logic              res_valid,
    output logic              par_bit,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr_cnt
);

    localparam int       BCNT_W   = $clog2(DATA_W);
    localparam logic     ODD_L    = (ODD != 0);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [DATA_W-1:0]   sreg_q,    sreg_d;
    logic [BCNT_W-1:0]   cnt_q,     cnt_d;
    logic                par_run_q, par_run_d;
    logic                in_par_q,  in_par_d;
    logic                par_bit_q, par_bit_d;
    logic                par_err_q, par_err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic accept;
    logic last_par;

    assign in_ready  = (state_q != SHIFT);
    assign accept    = in_valid && in_ready;
    assign ser_en    = (state_q == SHIFT);
    assign ser_x     = ser_en && sreg_q[0];
    assign res_valid = (state_q == CHECK);
    assign par_run   = par_run_q;
    assign par_bit   = par_bit_q;
    assign par_err   = par_err_q;
    assign err_cnt   = err_cnt_q;

    // Parity including the bit leaving on the final SHIFT cycle, so the result
    // registers are already settled when CHECK begins.
    assign last_par  = par_run_q ^ sreg_q[0] ^ ODD_L;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        par_run_d = par_run_q;
        in_par_d  = in_par_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    sreg_d    = in_data;
                    in_par_d  = in_par;
                    cnt_d     = '0;
                    par_run_d = 1'b0;
                end
            end
            SHIFT: begin
                sreg_d    = sreg_q >> 1;
                par_run_d = par_run_q ^ sreg_q[0];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d   = CHECK;
                    par_bit_d = last_par;
                    par_err_d = (last_par != in_par_q);
                end
            end
            CHECK: begin
                if (par_err_q && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (accept) begin
                    state_d   = SHIFT;
                    sreg_d    = in_data;
                    in_par_d  = in_par;
                    cnt_d     = '0;
                    par_run_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            par_run_q <= 1'b0;
            in_par_q  <= 1'b0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            par_run_q <= par_run_d;
            in_par_q  <= in_par_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Scoreboard bench: two controllers (even/2-bit counter, odd/8-bit counter)
// share one stimulus stream; expected results queue up per frame.
module tb_parity_frame_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       even_par;
        logic       in_par;
        int         res_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_par = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       rdy_e, sx_e, se_e, pr_e, rv_e, pb_e, pe_e;
    logic [1:0] cnt_e;
    logic       rdy_o, sx_o, se_o, pr_o, rv_o, pb_o, pe_o;
    logic [7:0] cnt_o;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q_e[$];
    exp_t q_o[$];
    logic [7:0] sh[2];
    int   nb[2];
    int   exp_cnt[2];

    parity_frame_ctrl #(.DATA_W(8), .ODD(0), .CNT_W(2)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_e),
        .in_data(in_data), .in_par(in_par), .ser_x(sx_e), .ser_en(se_e),
        .par_run(pr_e), .res_valid(rv_e), .par_bit(pb_e), .par_err(pe_e),
        .err_cnt(cnt_e), .clr_cnt(clr_cnt)
    );

    parity_frame_ctrl #(.DATA_W(8), .ODD(1), .CNT_W(8)) dut_o (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o),
        .in_data(in_data), .in_par(in_par), .ser_x(sx_o), .ser_en(se_o),
        .par_run(pr_o), .res_valid(rv_o), .par_bit(pb_o), .par_err(pe_o),
        .err_cnt(cnt_o), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_e"}, rdy_e, 1);  check({tag, "_ready_o"}, rdy_o, 1);
        check({tag, "_ser_x_e"}, sx_e, 0);   check({tag, "_ser_en_e"}, se_e, 0);
        check({tag, "_ser_en_o"}, se_o, 0);  check({tag, "_par_run_e"}, pr_e, 0);
        check({tag, "_res_valid_e"}, rv_e, 0); check({tag, "_res_valid_o"}, rv_o, 0);
        check({tag, "_par_bit_e"}, pb_e, 0); check({tag, "_par_err_e"}, pe_e, 0);
        check({tag, "_par_bit_o"}, pb_o, 0); check({tag, "_par_err_o"}, pe_o, 0);
        check({tag, "_err_cnt_e"}, cnt_e, 0); check({tag, "_err_cnt_o"}, cnt_o, 0);
    endtask

    // Offer one frame; even_par is the hand-computed XOR of the data bits.
    // Returns 1ns after the accepting edge, leaving in_valid high if keep_valid.
    task automatic send(input logic [7:0] data, input logic par, input logic even_par,
                        input logic keep_valid);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        in_data  = data;
        in_par   = par;
        waited   = 0;
        @(negedge clk);
        while (!rdy_e && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!rdy_e) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
        end else begin
            e.data     = data;
            e.even_par = even_par;
            e.in_par   = par;
            e.res_cyc  = cyc + 9;
            q_e.push_back(e);
            q_o.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic mon(input int idx, input logic rv, input logic sx, input logic se,
                       input logic pr, input logic pb, input logic pe, input int cnt,
                       input logic ready);
        exp_t e;
        logic empty;
        logic exp_pb;
        logic inc;
        int   max_cnt;
        string id;
        id      = (idx == 0) ? "even" : "odd";
        max_cnt = (idx == 0) ? 3 : 255;
        inc     = 1'b0;
        if (se) begin
            sh[idx] = {sx, sh[idx][7:1]};
            nb[idx]++;
        end
        if (rv) begin
            empty = (idx == 0) ? (q_e.size() == 0) : (q_o.size() == 0);
            if (empty) begin
                checks++;
                failures++;
                $display("FAIL unexpected_res_%s: got res_valid=1, required none pending (cyc=%0d)", id, cyc);
            end else begin
                e = (idx == 0) ? q_e.pop_front() : q_o.pop_front();
                exp_pb = e.even_par ^ (idx == 1);
                check({"serial_data_", id}, sh[idx], e.data);
                check({"serial_bits_", id}, nb[idx], 8);
                check({"res_cycle_", id}, cyc, e.res_cyc);
                check({"par_bit_", id}, pb, exp_pb);
                check({"par_err_", id}, pe, exp_pb != e.in_par);
                check({"par_run_", id}, pr, e.even_par);
                check({"ser_en_in_check_", id}, se, 0);
                check({"ready_in_check_", id}, ready, 1);
                check({"err_cnt_", id}, cnt, exp_cnt[idx]);
                inc = (exp_pb != e.in_par);
            end
            nb[idx] = 0;
        end
        if (clr_cnt) exp_cnt[idx] = 0;
        else if (inc && exp_cnt[idx] < max_cnt) exp_cnt[idx]++;
    endtask

    initial begin
        nb      = '{0, 0};
        exp_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb      = '{0, 0};
                exp_cnt = '{0, 0};
            end else begin
                mon(0, rv_e, sx_e, se_e, pr_e, pb_e, pe_e, int'(cnt_e), rdy_e);
                mon(1, rv_o, sx_o, se_o, pr_o, pb_o, pe_o, int'(cnt_o), rdy_o);
            end
        end
    end

    initial begin
        int waited;
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame and mismatch frame
        send(8'hB4, 1'b0, 1'b0, 1'b0);
        repeat (12) @(posedge clk); #1;
        send(8'h07, 1'b0, 1'b1, 1'b0);
        repeat (12) @(posedge clk); #1;

        // Back-to-back with in_valid held high through the first frame
        send(8'hFF, 1'b0, 1'b0, 1'b1);
        send(8'h01, 1'b1, 1'b1, 1'b0);
        repeat (12) @(posedge clk); #1;

        // Reset after the third serial bit of 8'hAA
        send(8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        q_e.delete();
        q_o.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h03, 1'b0, 1'b0, 1'b0);
        repeat (12) @(posedge clk); #1;

        // Saturation of the 2-bit counter, then clear racing an increment
        for (int i = 0; i < 5; i++) begin
            send(8'h01, 1'b0, 1'b1, 1'b0);
            repeat (10) @(posedge clk); #1;
        end
        send(8'h01, 1'b0, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 clr_cnt = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        check("clr_wins_err_cnt_even", cnt_e, 0);
        repeat (3) @(posedge clk); #1;

        // in_valid pulse mid-SHIFT must be ignored
        send(8'h0F, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 8'h55;
        in_par  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk); #1;
        check("hold_par_bit_even", pb_e, 0);
        check("hold_par_bit_odd", pb_o, 1);

        waited = 0;
        while ((q_e.size() != 0 || q_o.size() != 0) && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_even", q_e.size(), 0);
        check("drain_odd", q_o.size(), 0);
        check("final_err_cnt_even", cnt_e, exp_cnt[0]);
        check("final_err_cnt_odd", cnt_o, exp_cnt[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
